// File: rtl/sample_sched_pkg.sv
// Shared types and width helpers for the sample voice scheduler.
// SAMPLE_VOICE_SAT_EN widens the mix accumulator so the output can saturate.
package sample_sched_pkg;

    typedef enum logic [1:0] {
        VIdle,
        VPlayBtn,
        VPlaySeq
    } voice_state_e;

    typedef enum logic [2:0] {
        SIdle,
        SIssue,
        SWait,
        SCapt,
        SDone
    } sweep_state_e;

`ifdef SAMPLE_VOICE_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    // Headroom bits let the full sum of all voices be held before clamping.
    function automatic int unsigned acc_w(int unsigned data_w, int unsigned num_voices);
        return SatEn ? data_w + $clog2(num_voices) : data_w;
    endfunction

    function automatic int unsigned sel_w(int unsigned num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

endpackage

// File: rtl/voice_ctx.sv
// One voice: play state, address counter and trigger priority (button beats sequencer).
module voice_ctx
    import sample_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_trig_i,
    input  logic              seq_trig_i,
    input  logic [ADDR_W-1:0] depth_i,
    input  logic              in_slot_i,
    input  logic              capt_i,
    output voice_state_e      state_o,
    output logic [ADDR_W-1:0] addr_o
);

    voice_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              skip_q, skip_d;
    logic              btn_ok, seq_ok;

    assign btn_ok = btn_trig_i && (depth_i != '0);
    assign seq_ok = seq_trig_i && (depth_i != '0) && (state_q != VPlayBtn);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        skip_d  = skip_q;
        if (capt_i) begin
            skip_d = 1'b0;
        end
        if (btn_ok || seq_ok) begin
            state_d = btn_ok ? VPlayBtn : VPlaySeq;
            addr_d  = '0;
            // A restart mid-slot must not be advanced by this slot's capture.
            if (in_slot_i && !capt_i) begin
                skip_d = 1'b1;
            end
        end else if (capt_i && (state_q != VIdle) && !skip_q) begin
            if (addr_q == depth_i - ADDR_W'(1)) begin
                state_d = VIdle;
                addr_d  = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= VIdle;
            addr_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            skip_q  <= skip_d;
        end
    end

    assign state_o = state_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/sample_voice_sched.sv
// Sample voice scheduler: time-multiplexes one RAM read port across NUM_VOICES voices.
// Define SAMPLE_VOICE_SAT_EN for a widened accumulator with saturating mix output.
module sample_voice_sched
    import sample_sched_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RAM_LAT    = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_VOICES-1:0]        btn_trig,
    input  logic [NUM_VOICES-1:0]        seq_trig,
    input  logic [NUM_VOICES*ADDR_W-1:0] depth,
    input  logic                         sample_tick,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [sel_w(NUM_VOICES)-1:0] ram_sel,
    output logic                         ram_rden,
    input  logic [DATA_W-1:0]            ram_q,
    output logic [DATA_W-1:0]            mix_out,
    output logic                         mix_valid,
    output logic [NUM_VOICES-1:0]        playing,
    output logic [NUM_VOICES-1:0]        src_btn,
    output logic                         overrun
);

    localparam int unsigned AccW = acc_w(DATA_W, NUM_VOICES);
    localparam int unsigned SelW = sel_w(NUM_VOICES);
    localparam int unsigned CntW = $clog2(RAM_LAT + 1);
    localparam logic [SelW-1:0] LastV = SelW'(NUM_VOICES - 1);

    sweep_state_e      state_q;
    logic [SelW-1:0]   vidx_q;
    logic [CntW-1:0]   wcnt_q;
    logic              issued_q;
    logic [AccW-1:0]   acc_q, acc_sum;
    logic [DATA_W-1:0] mix_out_q, mix_next;
    logic              mix_valid_q, overrun_q;

    logic [NUM_VOICES-1:0] in_slot, capt;
    logic [ADDR_W-1:0]     vaddr [NUM_VOICES];

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_state_e st;

        assign in_slot[v] = (state_q inside {SIssue, SWait, SCapt}) && (vidx_q == SelW'(v));
        assign capt[v]    = (state_q == SCapt) && (vidx_q == SelW'(v));

        voice_ctx #(
            .ADDR_W(ADDR_W)
        ) u_voice (
            .clock     (clock),
            .reset     (reset),
            .btn_trig_i(btn_trig[v]),
            .seq_trig_i(seq_trig[v]),
            .depth_i   (depth[v*ADDR_W +: ADDR_W]),
            .in_slot_i (in_slot[v]),
            .capt_i    (capt[v]),
            .state_o   (st),
            .addr_o    (vaddr[v])
        );

        assign playing[v] = (st != VIdle);
        assign src_btn[v] = (st == VPlayBtn);
    end

    // Only a voice that was playing when its read was issued contributes.
    always_comb begin
        acc_sum = acc_q;
        if (issued_q) begin
            acc_sum = acc_q + AccW'(signed'(ram_q));
        end
    end

`ifdef SAMPLE_VOICE_SAT_EN
    always_comb begin
        mix_next = acc_sum[DATA_W-1:0];
        if (acc_sum[AccW-1:DATA_W-1] != {(AccW-DATA_W+1){acc_sum[AccW-1]}}) begin
            mix_next = acc_sum[AccW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign mix_next = acc_sum;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SIdle;
            vidx_q      <= '0;
            wcnt_q      <= '0;
            issued_q    <= 1'b0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;
            overrun_q   <= sample_tick && (state_q != SIdle);
            unique case (state_q)
                SIdle: begin
                    if (sample_tick) begin
                        state_q <= SIssue;
                        vidx_q  <= '0;
                    end
                end
                SIssue: begin
                    issued_q <= playing[vidx_q];
                    wcnt_q   <= CntW'(1);
                    state_q  <= (RAM_LAT > 1) ? SWait : SCapt;
                end
                SWait: begin
                    wcnt_q <= wcnt_q + CntW'(1);
                    if (wcnt_q == CntW'(RAM_LAT - 1)) begin
                        state_q <= SCapt;
                    end
                end
                SCapt: begin
                    acc_q <= acc_sum;
                    if (vidx_q == LastV) begin
                        state_q     <= SDone;
                        mix_out_q   <= mix_next;
                        mix_valid_q <= 1'b1;
                    end else begin
                        state_q <= SIssue;
                        vidx_q  <= vidx_q + SelW'(1);
                    end
                end
                SDone: begin
                    acc_q   <= '0;
                    state_q <= SIdle;
                end
                default: state_q <= SIdle;
            endcase
        end
    end

    assign ram_rden  = (state_q == SIssue) && playing[vidx_q];
    assign ram_sel   = ram_rden ? vidx_q : '0;
    assign ram_addr  = ram_rden ? vaddr[vidx_q] : '0;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_voice_sched.sv
// Randomized bench for sample_voice_sched against a sweep-timeline reference model.
module tb_sample_voice_sched;

    localparam int NV        = 2;
    localparam int AW        = 15;
    localparam int DW        = 16;
    localparam int LAT       = 2;
    localparam int SLOT      = LAT + 1;
    localparam int SWEEP_LEN = NV * SLOT + 1;
    localparam int AMASK     = (1 << AW) - 1;
`ifdef SAMPLE_VOICE_SAT_EN
    localparam int SAT_EXP = 'h7FFF;
`else
    localparam int SAT_EXP = 'hE000;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [NV-1:0]  btn_trig = '0;
    logic [NV-1:0]  seq_trig = '0;
    logic [NV*AW-1:0] depth = '0;
    logic           sample_tick = 1'b0;
    logic [AW-1:0]  ram_addr;
    logic [0:0]     ram_sel;
    logic           ram_rden;
    logic [DW-1:0]  ram_q = '0;
    logic [DW-1:0]  ram_s1 = '0;
    logic [DW-1:0]  mix_out;
    logic           mix_valid;
    logic [NV-1:0]  playing;
    logic [NV-1:0]  src_btn;
    logic           overrun;

    int n_tests = 0;
    int n_fail  = 0;
    bit fixed_mode = 1'b0;

    sample_voice_sched #(
        .NUM_VOICES(NV),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RAM_LAT   (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_trig   (btn_trig),
        .seq_trig   (seq_trig),
        .depth      (depth),
        .sample_tick(sample_tick),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .playing    (playing),
        .src_btn    (src_btn),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    function automatic int mem_val(int sel, int addr);
        if (fixed_mode) return 'h7000;
        return ((addr * 40503) ^ (sel * 9973) ^ 'h5A3C) & 'hFFFF;
    endfunction

    // Sample RAM with two-cycle read latency; unread cycles return junk.
    always @(posedge clock) begin
        ram_s1 <= ram_rden ? DW'(mem_val(int'(ram_sel), int'(ram_addr))) : 16'hDEAD;
        ram_q  <= ram_s1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model. m_sweep = 0 when idle, else the 1-based cycle within a sweep.
    int m_st [NV];  // 0 idle, 1 button play, 2 sequencer play
    int m_addr [NV];
    bit m_restart [NV];
    int m_sweep, m_acc, m_data, m_mix;
    bit m_issued, m_valid, m_ovr;

    function automatic void model_init();
        for (int v = 0; v < NV; v++) begin
            m_st[v] = 0;
            m_addr[v] = 0;
            m_restart[v] = 0;
        end
        m_sweep = 0; m_acc = 0; m_data = 0; m_mix = 0;
        m_issued = 0; m_valid = 0; m_ovr = 0;
    endfunction

    function automatic int depth_of(int v);
        return int'(depth[v*AW +: AW]);
    endfunction

    function automatic int sext16(int x);
        return ((x & 'h8000) != 0) ? x - 'h10000 : x;
    endfunction

    function automatic int map_mix(int a);
`ifdef SAMPLE_VOICE_SAT_EN
        if (a > 32767) return 'h7FFF;
        if (a < -32768) return 'h8000;
`endif
        return a & 'hFFFF;
    endfunction

    function automatic void voice_step(int v, bit in_slot, bit capt);
        int d = depth_of(v);
        bit btn = btn_trig[v] && (d != 0);
        bit seq = seq_trig[v] && (d != 0) && (m_st[v] != 1);
        if (btn || seq) begin
            m_st[v] = btn ? 1 : 2;
            m_addr[v] = 0;
            m_restart[v] = in_slot && !capt;
        end else if (capt) begin
            if (m_st[v] != 0 && !m_restart[v]) begin
                if (m_addr[v] == ((d - 1) & AMASK)) begin
                    m_st[v] = 0;
                    m_addr[v] = 0;
                end else begin
                    m_addr[v] = (m_addr[v] + 1) & AMASK;
                end
            end
            m_restart[v] = 0;
        end
    endfunction

    function automatic void model_step();
        int sv = -1;
        int ph = -1;
        m_ovr = sample_tick && (m_sweep != 0);
        m_valid = 0;
        if (m_sweep >= 1 && m_sweep <= NV * SLOT) begin
            sv = (m_sweep - 1) / SLOT;
            ph = (m_sweep - 1) % SLOT;
        end
        if (ph == 0) begin
            m_issued = (m_st[sv] != 0);
            m_data = mem_val(sv, m_addr[sv]);
        end
        if (ph == LAT) begin
            if (m_issued) m_acc += sext16(m_data);
            if (sv == NV - 1) begin
                m_mix = map_mix(m_acc);
                m_valid = 1;
            end
        end
        for (int v = 0; v < NV; v++) voice_step(v, sv == v, (sv == v) && (ph == LAT));
        if (m_sweep == SWEEP_LEN) m_acc = 0;
        if (m_sweep == 0) m_sweep = sample_tick ? 1 : 0;
        else if (m_sweep == SWEEP_LEN) m_sweep = 0;
        else m_sweep++;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) model_init();
        else model_step();
    end

    task automatic check_outputs();
        logic [NV-1:0] ep, eb;
        int sv = -1;
        bit er = 0;
        for (int v = 0; v < NV; v++) begin
            ep[v] = (m_st[v] != 0);
            eb[v] = (m_st[v] == 1);
        end
        if (m_sweep >= 1 && m_sweep <= NV * SLOT && ((m_sweep - 1) % SLOT) == 0) begin
            sv = (m_sweep - 1) / SLOT;
            er = (m_st[sv] != 0);
        end
        check_eq("playing", playing, ep);
        check_eq("src_btn", src_btn, eb);
        check_eq("ram_rden", ram_rden, er);
        if (er) begin
            check_eq("ram_addr", ram_addr, m_addr[sv]);
            check_eq("ram_sel", ram_sel, sv);
        end
        check_eq("mix_valid", mix_valid, m_valid);
        check_eq("mix_out", mix_out, m_mix);
        check_eq("overrun", overrun, m_ovr);
    endtask

    always @(negedge clock) check_outputs();

    int cyc_no, seen_reads0, seen_valid, seen_ovr, last_valid_cyc, first_addr1;

    task automatic clear_tally();
        cyc_no = 0; seen_reads0 = 0; seen_valid = 0; seen_ovr = 0;
        last_valid_cyc = -1; first_addr1 = -1;
    endtask

    // Drive one cycle of inputs, then observe outputs at the falling edge.
    task automatic step(input logic [NV-1:0] b, input logic [NV-1:0] s, input logic t);
        @(posedge clock);
        #1;
        btn_trig = b;
        seq_trig = s;
        sample_tick = t;
        @(negedge clock);
        if (ram_rden && ram_sel == 1'b0) seen_reads0++;
        if (ram_rden && ram_sel == 1'b1 && first_addr1 < 0) first_addr1 = int'(ram_addr);
        if (mix_valid) begin
            seen_valid++;
            last_valid_cyc = cyc_no;
        end
        if (overrun) seen_ovr++;
        cyc_no++;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        btn_trig = '0;
        seq_trig = '0;
        sample_tick = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst_mix_out", mix_out, 0);
        check_eq("rst_mix_valid", mix_valid, 0);
        check_eq("rst_ram_rden", ram_rden, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_sel", ram_sel, 0);
        check_eq("rst_playing", playing, 0);
        check_eq("rst_src_btn", src_btn, 0);
        check_eq("rst_overrun", overrun, 0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        repeat (3) step('0, '0, 1'b0);

        // One voice, depth 4, five sweeps.
        depth = {15'd0, 15'd4};
        step(2'b01, '0, 1'b0);
        clear_tally();
        repeat (5) begin
            step('0, '0, 1'b1);
            repeat (9) step('0, '0, 1'b0);
        end
        check_eq("v0_reads", seen_reads0, 4);
        check_eq("v0_sweeps", seen_valid, 5);
        check_eq("v0_stopped", playing[0], 0);
        check_eq("v0_silent", mix_out, 0);

        // Sequencer play retriggered by button at address 7.
        do_reset();
        depth = {15'd20, 15'd0};
        step('0, 2'b10, 1'b0);
        repeat (7) begin
            step('0, '0, 1'b1);
            repeat (8) step('0, '0, 1'b0);
        end
        check_eq("seq_src", src_btn[1], 0);
        step(2'b10, '0, 1'b0);
        step('0, '0, 1'b0);
        check_eq("btn_src", src_btn[1], 1);
        step('0, 2'b10, 1'b0);
        step('0, '0, 1'b0);
        check_eq("seq_ignored", src_btn[1], 1);
        clear_tally();
        step('0, '0, 1'b1);
        repeat (8) step('0, '0, 1'b0);
        check_eq("retrig_addr", first_addr1, 0);

        // Both voices read 0x7000.
        do_reset();
        fixed_mode = 1'b1;
        depth = {15'd10, 15'd10};
        step(2'b11, '0, 1'b0);
        step('0, '0, 1'b1);
        repeat (8) step('0, '0, 1'b0);
        check_eq("sat_mix", mix_out, SAT_EXP);
        fixed_mode = 1'b0;
        repeat (30) step('0, '0, 1'b0);

        // Second tick at sweep cycle 3 is dropped.
        clear_tally();
        step('0, '0, 1'b1);
        repeat (2) step('0, '0, 1'b0);
        step('0, '0, 1'b1);
        repeat (8) step('0, '0, 1'b0);
        check_eq("ovr_count", seen_ovr, 1);
        check_eq("ovr_valid_count", seen_valid, 1);
        check_eq("ovr_valid_cycle", last_valid_cyc, 7);

        // Reset while the first slot is waiting on RAM.
        depth = {15'd10, 15'd10};
        step(2'b11, '0, 1'b0);
        clear_tally();
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        do_reset();
        repeat (6) step('0, '0, 1'b0);
        check_eq("rst_no_valid", seen_valid, 0);
        step('0, '0, 1'b1);
        repeat (8) step('0, '0, 1'b0);
        check_eq("post_rst_valid", seen_valid, 1);
        check_eq("post_rst_mix", mix_out, 0);

        // Random triggers, ticks and depths.
        for (int i = 0; i < 3000; i++) begin
            logic [NV-1:0] b, s;
            logic t;
            if ($urandom_range(0, 99) == 0) begin
                for (int v = 0; v < NV; v++) depth[v*AW +: AW] = AW'($urandom_range(0, 6));
            end
            for (int v = 0; v < NV; v++) begin
                b[v] = ($urandom_range(0, 39) == 0);
                s[v] = ($urandom_range(0, 24) == 0);
            end
            t = ($urandom_range(0, 9) == 0);
            step(b, s, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_voice_sched.md
SAMPLE_VOICE_SCHED -- requirements
Module: sample_voice_sched

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 2: number of sample voices sharing one RAM read port.
REQ-002 SHALL have parameter ADDR_W, default 15: sample address width.
REQ-003 SHALL have parameter DATA_W, default 16: signed sample and mix width.
REQ-004 SHALL have parameter RAM_LAT, default 2: cycles from ram_rden to valid ram_q.
REQ-005 SHALL have port clock, input, 1: single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port btn_trig, input, NUM_VOICES: live pad trigger pulses.
REQ-008 SHALL have port seq_trig, input, NUM_VOICES: sequencer trigger pulses.
REQ-009 SHALL have port depth, input, NUM_VOICES*ADDR_W: per-voice sample length; voice v uses slice v.
REQ-010 SHALL have port sample_tick, input, 1: audio-rate strobe that starts one mix sweep.
REQ-011 SHALL have port ram_addr, output, ADDR_W: read address.
REQ-012 SHALL have port ram_sel, output, clog2(NUM_VOICES): RAM bank select.
REQ-013 SHALL have port ram_rden, output, 1: read strobe.
REQ-014 SHALL have port ram_q, input, DATA_W: read data.
REQ-015 SHALL have port mix_out, output, DATA_W: mixed sample, held between sweeps.
REQ-016 SHALL have port mix_valid, output, 1: one-cycle pulse when mix_out updates.
REQ-017 SHALL have port playing, output, NUM_VOICES: voice active.
REQ-018 SHALL have port src_btn, output, NUM_VOICES: active voice was started by a button.
REQ-019 SHALL have port overrun, output, 1: one-cycle pulse when a sample_tick is dropped.

Function
REQ-020 Each voice SHALL hold state IDLE, PLAY_BTN or PLAY_SEQ, plus an address counter.
- btn_trig[v] in any state: go to PLAY_BTN and reset the address to 0 (retrigger).
- seq_trig[v] in IDLE or PLAY_SEQ: go to PLAY_SEQ with address 0.
- seq_trig[v] in PLAY_BTN: ignore.
- btn_trig and seq_trig in the same cycle: btn_trig wins.
REQ-021 A trigger with depth slice 0 SHALL be ignored.
REQ-022 The sweep FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT, S_CAPT and S_DONE.
- sample_tick in S_IDLE: go to S_ISSUE for voice 0.
- Each voice gets a fixed slot: S_ISSUE for 1 cycle, then S_WAIT for RAM_LAT-1 cycles, then S_CAPT for 1 cycle.
- After the last voice: S_DONE for 1 cycle, then S_IDLE.
- Sweep length: NUM_VOICES*(RAM_LAT+1)+1 cycles.
REQ-023 In S_ISSUE, for an active voice: ram_rden=1, ram_sel=v, ram_addr=address.
- For an idle voice: ram_rden=0, and the voice contributes 0.
- ram_rden SHALL be 0 in every other state.
REQ-024 In S_CAPT, an active voice SHALL add sign-extended ram_q to the accumulator.
- The address then increments.
- If the captured address equals depth-1, the voice goes to IDLE instead.
REQ-025 A trigger that lands during voice v's own slot SHALL take effect next cycle.
- The in-flight read still accumulates.
- The counter restarts at 0, and the S_CAPT increment for that slot is suppressed.
REQ-026 In S_DONE, mix_out SHALL load the accumulator, subject to REQ-032.
- mix_valid SHALL pulse in the same cycle.
- The accumulator SHALL clear.
REQ-027 sample_tick outside S_IDLE SHALL be dropped and SHALL pulse overrun.
REQ-028 playing[v] SHALL be 1 exactly when voice v is not IDLE, and src_btn[v] SHALL be 1 exactly in PLAY_BTN.

Reset
REQ-029 While reset is low: all voices IDLE, addresses 0, FSM S_IDLE, accumulator 0.
- Outputs: mix_out=0, mix_valid=0, ram_rden=0, ram_addr=0, ram_sel=0, playing=0, src_btn=0, overrun=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no mix_valid pulse.
REQ-031 After reset deassertion, the first sample_tick SHALL be honoured.

Configuration
REQ-032 Macro SAMPLE_VOICE_SAT_EN SHALL select how the sum maps to mix_out.
- Defined: the accumulator is DATA_W+clog2(NUM_VOICES) bits, and mix_out saturates to the signed DATA_W min/max.
- Undefined: mix_out is the low DATA_W bits of the sum (two's-complement wrap).

Structure
REQ-033 Package sample_sched_pkg SHALL hold the voice-state and sweep-state enums, plus the ACC_W derivation.
REQ-034 Sub-module voice_ctx SHALL implement one voice's state, address counter and trigger priority.
- It is instantiated NUM_VOICES times.
- The scheduler owns the sweep FSM, accumulator and RAM port.

Verification
REQ-035 One voice, btn_trig[0] with depth0=4, then 5 ticks:
- Reads at addresses 0,1,2,3 on ram_sel=0.
- playing[0] falls after the 4th S_CAPT.
- The 5th tick gives ram_rden=0 and mix_out=0.
REQ-036 seq_trig[1] active, then btn_trig[1] while at address 7:
- Next sweep reads address 0.
- src_btn[1]=1, and a following seq_trig[1] is ignored.
REQ-037 Saturation check, ram_q=0x7000 for both voices:
- With SAMPLE_VOICE_SAT_EN: mix_out=0x7FFF.
- Without: mix_out=0xE000.
REQ-038 Overrun check, sample_tick at sweep cycles 0 and 3 (RAM_LAT=2):
- overrun pulses once.
- Exactly one mix_valid pulse, at cycle 7.
REQ-039 Reset asserted in S_WAIT:
- All outputs reach their reset values without a clock edge.
- No mix_valid pulse.
- Next tick gives mix_out=0.
